// File: rtl/data_sram_resp_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package data_sram_resp_pkg;

    localparam int DEPTH_DEF = 1024;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] WT_BYTE = 2'b00;
    localparam logic [1:0] WT_HALF = 2'b01;
    localparam logic [1:0] WT_WORD = 2'b10;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_HI,
        ST_WR_A,
        ST_WR_B
    } state_e;

    function automatic size_e load_size(input logic [2:0] t);
        size_e sz;
        case (t)
            LD_LB, LD_LBU: sz = SZ_B;
            LD_LH, LD_LHU: sz = SZ_H;
            default:       sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic size_e store_size(input logic [1:0] t);
        size_e sz;
        case (t)
            WT_BYTE: sz = SZ_B;
            WT_HALF: sz = SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        return ((sz == SZ_H) && (off == 2'd3)) || ((sz == SZ_W) && (off != 2'd0));
    endfunction

    // Byte mask across two consecutive words: [3:0] first word, [7:4] second.
    function automatic logic [7:0] byte_mask8(input size_e sz, input logic [1:0] off);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m << off;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] t, input logic [31:0] v);
        logic [31:0] r;
        case (t)
            LD_LB:   r = {{24{v[7]}}, v[7:0]};
            LD_LH:   r = {{16{v[15]}}, v[15:0]};
            LD_LBU:  r = {24'h0, v[7:0]};
            LD_LHU:  r = {16'h0, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_sram_resp_sram_bytelane.sv
// Word array with per-byte write enables, synchronous write, combinational read.
// Latency: write lands at the clock edge, read is same-cycle (pre-write data).
// Backpressure: none, accepts one write and one read every cycle.
module sram_bytelane #(
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [3:0]    be,
    input  logic [31:0]   wdat,
    input  logic [IW-1:0] ridx,
    output logic [31:0]   rdat
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[widx][8*b +: 8] <= wdat[8*b +: 8];
                end
            end
        end
    end

    assign rdat = mem[ridx];

endmodule

// File: rtl/data_sram_resp.sv
// Load/store responder: byte/half/word access with misaligned split via a small FSM.
// Latency: aligned load 1 cycle, misaligned load 2 cycles; aligned store same cycle.
// Backpressure: busy_o high while splitting; requests arriving then are ignored.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    input  logic [2:0]    rtype_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [1:0]    wtype_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o,
    output logic          rvalid_o,
    output logic          busy_o
);

    localparam int IW = $clog2(DEPTH);
    typedef logic [IW-1:0] idx_t;

    state_e        state_q, state_d;
    logic [2:0]    rtype_q, rtype_d;
    logic [1:0]    roff_q, roff_d;
    logic [31:0]   rlo_q, rlo_d;
    idx_t          rhi_idx_q, rhi_idx_d;
    logic          pw_pend_q, pw_pend_d;
    logic [IW+1:0] pw_addr_q, pw_addr_d;
    logic [1:0]    pw_type_q, pw_type_d;
    logic [31:0]   pw_data_q, pw_data_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;

    logic          mem_we;
    idx_t          mem_widx;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdat;
    idx_t          mem_ridx;
    logic [31:0]   mem_rdat;

    idx_t          rd_idx, wr_idx, pw_idx;
    logic          rd_mis, wr_mis, pw_mis, both_aligned;
    logic [7:0]    wr_be8, pw_be8;
    logic [63:0]   wr_sh, pw_sh, merged;
    logic          unused_bits;

    assign rd_idx = raddr_i[IW+1:2];
    assign wr_idx = waddr_i[IW+1:2];
    assign pw_idx = pw_addr_q[IW+1:2];

    assign rd_mis = is_misaligned(load_size(rtype_i), raddr_i[1:0]);
    assign wr_mis = is_misaligned(store_size(wtype_i), waddr_i[1:0]);
    assign pw_mis = is_misaligned(store_size(pw_type_q), pw_addr_q[1:0]);

    // A misaligned read in the same cycle forces the write to be deferred so
    // the read still observes pre-write data in both of its words.
    assign both_aligned = !wr_mis && !(re_i && rd_mis);

    assign wr_be8 = byte_mask8(store_size(wtype_i), waddr_i[1:0]);
    assign pw_be8 = byte_mask8(store_size(pw_type_q), pw_addr_q[1:0]);
    assign wr_sh  = {32'h0, wdata_i} << {waddr_i[1:0], 3'b000};
    assign pw_sh  = {32'h0, pw_data_q} << {pw_addr_q[1:0], 3'b000};

    assign unused_bits = ^{raddr_i[AW-1:IW+2], waddr_i[AW-1:IW+2],
                           wr_sh[63:32], wr_be8[7:4], merged[63:32]};

    always_comb begin
        state_d   = state_q;
        rtype_d   = rtype_q;
        roff_d    = roff_q;
        rlo_d     = rlo_q;
        rhi_idx_d = rhi_idx_q;
        pw_pend_d = pw_pend_q;
        pw_addr_d = pw_addr_q;
        pw_type_d = pw_type_q;
        pw_data_d = pw_data_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        merged    = 64'h0;
        mem_we    = 1'b0;
        mem_widx  = wr_idx;
        mem_be    = 4'h0;
        mem_wdat  = 32'h0;
        mem_ridx  = rd_idx;

        case (state_q)
            ST_IDLE: begin
                if (re_i) begin
                    if (rd_mis) begin
                        rlo_d     = mem_rdat;
                        rtype_d   = rtype_i;
                        roff_d    = raddr_i[1:0];
                        rhi_idx_d = rd_idx + idx_t'(1);
                    end else begin
                        rdata_d  = load_extend(rtype_i, mem_rdat >> {raddr_i[1:0], 3'b000});
                        rvalid_d = 1'b1;
                    end
                end
                if (we_i) begin
                    if (both_aligned) begin
                        mem_we   = 1'b1;
                        mem_widx = wr_idx;
                        mem_be   = wr_be8[3:0];
                        mem_wdat = wr_sh[31:0];
                    end else begin
                        pw_pend_d = 1'b1;
                        pw_addr_d = waddr_i[IW+1:0];
                        pw_type_d = wtype_i;
                        pw_data_d = wdata_i;
                    end
                end
                if (re_i && rd_mis) begin
                    state_d = ST_RD_HI;
                end else if (we_i && !both_aligned) begin
                    state_d = ST_WR_A;
                end
            end
            ST_RD_HI: begin
                mem_ridx = rhi_idx_q;
                merged   = {mem_rdat, rlo_q} >> {roff_q, 3'b000};
                rdata_d  = load_extend(rtype_q, merged[31:0]);
                rvalid_d = 1'b1;
                state_d  = pw_pend_q ? ST_WR_A : ST_IDLE;
            end
            ST_WR_A: begin
                mem_we   = 1'b1;
                mem_widx = pw_idx;
                mem_be   = pw_be8[3:0];
                mem_wdat = pw_sh[31:0];
                if (pw_mis) begin
                    state_d = ST_WR_B;
                end else begin
                    pw_pend_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_WR_B: begin
                mem_we    = 1'b1;
                mem_widx  = pw_idx + idx_t'(1);
                mem_be    = pw_be8[7:4];
                mem_wdat  = pw_sh[63:32];
                pw_pend_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rtype_q   <= 3'h0;
            roff_q    <= 2'h0;
            rlo_q     <= 32'h0;
            rhi_idx_q <= '0;
            pw_pend_q <= 1'b0;
            pw_addr_q <= '0;
            pw_type_q <= 2'h0;
            pw_data_q <= 32'h0;
            rdata_q   <= 32'h0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rtype_q   <= rtype_d;
            roff_q    <= roff_d;
            rlo_q     <= rlo_d;
            rhi_idx_q <= rhi_idx_d;
            pw_pend_q <= pw_pend_d;
            pw_addr_q <= pw_addr_d;
            pw_type_q <= pw_type_d;
            pw_data_q <= pw_data_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // No array writes land while reset is held, so an aborted split stops cleanly.
    sram_bytelane #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we & rst),
        .widx (mem_widx),
        .be   (mem_be),
        .wdat (mem_wdat),
        .ridx (mem_ridx),
        .rdat (mem_rdat)
    );

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: aligned/misaligned loads and stores, ordering, wrap, reset abort.
module tb_data_sram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        re_i;
    logic [31:0] raddr_i;
    logic [2:0]  rtype_i;
    logic        we_i;
    logic [31:0] waddr_i;
    logic [1:0]  wtype_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    logic busy_seen = 1'b0;

    always #5 clk = ~clk;

    always @(negedge clk) if (busy_o === 1'b1) busy_seen = 1'b1;

    data_sram_resp #(.DEPTH(1024), .AW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .re_i     (re_i),
        .raddr_i  (raddr_i),
        .rtype_i  (rtype_i),
        .we_i     (we_i),
        .waddr_i  (waddr_i),
        .wtype_i  (wtype_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o),
        .busy_o   (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o !== 1'b0 && n < 8) begin
            tick();
            n++;
        end
        if (busy_o !== 1'b0) check({tag, "_busy_timeout"}, 32'(busy_o), 32'h0);
    endtask

    task automatic sw(input logic [31:0] a, input logic [1:0] t, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wtype_i = t; wdata_i = d;
        tick();
        we_i = 1'b0;
        wait_idle("sw");
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] t, input logic [31:0] exp,
                      input int exp_lat, input string tag);
        int lat = 1;
        re_i = 1'b1; raddr_i = a; rtype_i = t;
        tick();
        re_i = 1'b0;
        while (rvalid_o !== 1'b1 && lat < 6) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, rdata_o, exp);
        tick();
        check({tag, "_pulse"}, 32'(rvalid_o), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; re_i = 1'b0; raddr_i = '0; rtype_i = 3'b010;
        we_i = 1'b0; waddr_i = '0; wtype_i = 2'b10; wdata_i = '0;
        tick(); tick();
        rst = 1'b1;
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_rvalid", 32'(rvalid_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);

        // Aligned word store then load, no stall
        busy_seen = 1'b0;
        sw(32'h10, 2'b10, 32'h80FF7F01);
        ld(32'h10, 3'b010, 32'h80FF7F01, 1, "lw10");
        check("lw10_nobusy", 32'(busy_seen), 32'h0);

        // Sub-word extension
        ld(32'h13, 3'b000, 32'hFFFFFF80, 1, "lb13");
        ld(32'h13, 3'b100, 32'h00000080, 1, "lbu13");
        ld(32'h12, 3'b001, 32'hFFFF80FF, 1, "lh12");
        ld(32'h10, 3'b101, 32'h00007F01, 1, "lhu10");
        ld(32'h10, 3'b011, 32'h80FF7F01, 1, "rt011");

        // Misaligned load with request held during busy
        sw(32'h20, 2'b10, 32'h11223344);
        sw(32'h24, 2'b10, 32'h55667788);
        re_i = 1'b1; raddr_i = 32'h22; rtype_i = 3'b010;
        tick();
        check("lw22_busy", 32'(busy_o), 32'h1);
        check("lw22_novalid", 32'(rvalid_o), 32'h0);
        tick();
        re_i = 1'b0;
        check("lw22_valid", 32'(rvalid_o), 32'h1);
        check("lw22_data", rdata_o, 32'h77881122);
        check("lw22_busy_fall", 32'(busy_o), 32'h0);
        tick();
        check("lw22_single", 32'(rvalid_o), 32'h0);

        // Misaligned word store: two write cycles
        sw(32'h30, 2'b10, 32'h01020304);
        sw(32'h34, 2'b10, 32'h05060708);
        we_i = 1'b1; waddr_i = 32'h31; wtype_i = 2'b10; wdata_i = 32'hAABBCCDD;
        tick();
        we_i = 1'b0;
        check("sw31_wra", 32'(busy_o), 32'h1);
        tick();
        check("sw31_wrb", 32'(busy_o), 32'h1);
        tick();
        check("sw31_idle", 32'(busy_o), 32'h0);
        ld(32'h30, 3'b010, 32'hBBCCDD04, 1, "w30");
        ld(32'h34, 3'b010, 32'h050607AA, 1, "w34");

        // Same-cycle read and write: read sees old data
        sw(32'h40, 2'b10, 32'hDEADBEEF);
        re_i = 1'b1; raddr_i = 32'h40; rtype_i = 3'b010;
        we_i = 1'b1; waddr_i = 32'h40; wtype_i = 2'b10; wdata_i = 32'h12345678;
        tick();
        re_i = 1'b0; we_i = 1'b0;
        check("rw40_valid", 32'(rvalid_o), 32'h1);
        check("rw40_old", rdata_o, 32'hDEADBEEF);
        check("rw40_busy", 32'(busy_o), 32'h0);
        ld(32'h40, 3'b010, 32'h12345678, 1, "rw40_new");

        // Misaligned read with aligned write: RD_HI then deferred WR_A
        sw(32'h44, 2'b10, 32'h0BADF00D);
        re_i = 1'b1; raddr_i = 32'h42; rtype_i = 3'b010;
        we_i = 1'b1; waddr_i = 32'h40; wtype_i = 2'b10; wdata_i = 32'h9ABCDEF0;
        tick();
        re_i = 1'b0; we_i = 1'b0;
        check("rw42_rdhi", 32'(busy_o), 32'h1);
        tick();
        check("rw42_wra", 32'(busy_o), 32'h1);
        check("rw42_valid", 32'(rvalid_o), 32'h1);
        check("rw42_old", rdata_o, 32'hF00D1234);
        tick();
        check("rw42_idle", 32'(busy_o), 32'h0);
        ld(32'h40, 3'b010, 32'h9ABCDEF0, 1, "rw42_w40");
        ld(32'h44, 3'b010, 32'h0BADF00D, 1, "rw42_w44");

        // Wrap from last word to word 0
        sw(32'hFFC, 2'b10, 32'hCAFEBABE);
        sw(32'h000, 2'b10, 32'h13579BDF);
        ld(32'hFFE, 3'b010, 32'h9BDFCAFE, 2, "wrap");

        // Reset during WR_A aborts the second half
        sw(32'h50, 2'b10, 32'h00000000);
        sw(32'h54, 2'b10, 32'h11111111);
        we_i = 1'b1; waddr_i = 32'h52; wtype_i = 2'b10; wdata_i = 32'hFFFFFFFF;
        tick();
        we_i = 1'b0;
        check("abort_in_wra", 32'(busy_o), 32'h1);
        rst = 1'b0;
        tick();
        check("abort_busy", 32'(busy_o), 32'h0);
        check("abort_rvalid", 32'(rvalid_o), 32'h0);
        check("abort_rdata", rdata_o, 32'h0);
        rst = 1'b1;
        tick();
        check("abort_stay_idle", 32'(busy_o), 32'h0);
        ld(32'h54, 3'b010, 32'h11111111, 1, "abort_w54");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Data-memory responder for the RV32IM core: the far end of the load/store request interface issued by decode/execute.
- Accepts one read request (`re_i`) and one write request (`we_i`) per cycle and serves them from a word-organised, little-endian internal array.
- Loads return sign- or zero-extended byte/half/word data; stores apply byte/half/word writes.
- Misaligned accesses are split into two word accesses by a small FSM, which stalls the pipeline via `busy_o`.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- AW, 32, byte-address width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low (rst==0 resets)
- re_i  in  1  read request
- raddr_i  in  AW  read byte address
- rtype_i  in  3  load type, funct3 encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- we_i  in  1  write request
- waddr_i  in  AW  write byte address
- wtype_i  in  2  store type: 00 byte, 01 half, 10 word
- wdata_i  in  32  store data; byte/half taken from low bits
- rdata_o  out  32  extended load result
- rvalid_o  out  1  single-cycle pulse, rdata_o valid
- busy_o  out  1  high while FSM not IDLE; requests ignored

Behaviour:
- Reset (rst==0 at posedge): rdata_o=0, rvalid_o=0, busy_o=0, state=IDLE, pending registers cleared. Memory contents are not reset.
- Reset mid-operation aborts the sequence. A write half already committed stays; the remaining half is discarded. No rvalid_o is produced for an aborted read.
- Addressing:
  - Word index = addr[log2(DEPTH)+1:2], wrapping modulo DEPTH.
  - Offset = addr[1:0].
  - The second word of a split access is index+1 mod DEPTH (last word wraps to word 0).
- Misaligned means: half with offset==3, or word with offset!=0. All other accesses are aligned.
- States: IDLE, RD_HI, WR_A, WR_B. busy_o = (state!=IDLE), combinational from state.
- IDLE, requests sampled only here:
  - re_i: read low word at raddr, capture rtype and offset.
  - we_i, both requests aligned: write in the same cycle with byte-enables per wtype/offset.
  - we_i otherwise: capture waddr/wtype/wdata into pending registers, no write this cycle.
  - Next state: read misaligned -> RD_HI; else pending write -> WR_A; else IDLE.
- Aligned read: rvalid_o=1 and rdata_o valid in the cycle after acceptance (latency 1).
- RD_HI:
  - Read the next word and merge bytes.
  - rvalid_o pulses in the cycle after RD_HI (latency 2).
  - Next state: pending write -> WR_A, else IDLE.
- WR_A: write the low part of the pending store. Next state: misaligned -> WR_B, else IDLE.
- WR_B: write the remaining bytes into the next word. Next state: IDLE.
- Ordering: a read accepted in the same cycle as a write always returns pre-write data, whether the write is same-cycle or deferred.
- Extension:
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - rtype 011/110/111: treated as LW.
- Outputs between reads:
  - rvalid_o=0 in every cycle without a completing read.
  - rdata_o holds its last value.
- Requests arriving while busy_o=1 are ignored; the requester holds them until busy_o falls.

Decomposition:
- Shared defines:
  - load/store type encodings
  - FSM state encodings
  - DEPTH default
- Sub-module `sram_bytelane`: single-port-write / single-port-read word array with 4-bit byte-enable, synchronous write, combinational read, no reset.
- FSM, merge, and extension logic live in `data_sram_resp`.

Test Plan:
- Reset then SW 0x80FF7F01 @0x10, next cycle LW @0x10 -> rvalid_o after 1 cycle, rdata_o=0x80FF7F01, busy_o never high.
- LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LH @0x12 -> 0xFFFF80FF; LHU @0x10 -> 0x00007F01.
- SW 0x11223344 @0x20, SW 0x55667788 @0x24, then LW @0x22 -> busy_o high 1 cycle (RD_HI), rvalid_o 2 cycles after accept, rdata_o=0x77881122; re_i held during busy is not double-served.
- SW 0xAABBCCDD @0x31 (misaligned) -> busy_o 2 cycles (WR_A, WR_B); word 0x30 bytes[3:1]=DD,CC,BB; word 0x34 byte0=AA, other bytes unchanged.
- Simultaneous LW @0x40 (old 0xDEADBEEF) and SW 0x12345678 @0x40 -> rdata_o=0xDEADBEEF, memory then 0x12345678. Misaligned variant LW @0x42 + SW @0x40 -> read first, write in WR_A.
- LW @ byte addr 4*DEPTH-2 -> wraps, upper half from word 0. rst=0 asserted during WR_A of a misaligned store -> no WR_B write, outputs 0, state IDLE.
